// File: rtl/accel_hash_multi.sv
// Multi-channel Toeplitz (RSS-style) hash accelerator behind a simple word-addressed IO bus.
// Each channel hashes one byte per clock against a shared, software-writable key.
module accel_hash_multi #(
    parameter int IO_DATA_WIDTH = 32,
    parameter int IO_STRB_WIDTH = IO_DATA_WIDTH / 8,
    parameter int IO_ADDR_WIDTH = 22,
    parameter int CHANNELS      = 4,
    parameter int KEY_BITS      = 320,
    parameter logic [KEY_BITS-1:0] KEY_INIT =
        320'h6d5a56da255b0ec24167253d43a38fb0d0ca2bcbae7b30b477cb2da38030f20c6a42b73bbeac01fa
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     io_en,
    input  logic                     io_wen,
    input  logic [IO_STRB_WIDTH-1:0] io_strb,
    input  logic [IO_ADDR_WIDTH-1:0] io_addr,
    input  logic [IO_DATA_WIDTH-1:0] io_wr_data,
    output logic [IO_DATA_WIDTH-1:0] io_rd_data,
    output logic                     io_rd_valid,
    output logic                     error,
    input  logic                     error_ack
);

    localparam int KEY_WORDS = KEY_BITS / 32;
    localparam logic [7:0] SAT_CNT = 8'(KEY_BITS / 8 - 4);

    typedef enum logic {IDLE, BUSY} state_t;

    logic [KEY_BITS-1:0] key_q;

    state_t      state_q [CHANNELS];
    state_t      state_d [CHANNELS];
    logic [31:0] hash_q  [CHANNELS];
    logic [31:0] hash_d  [CHANNELS];
    logic [7:0]  cnt_q   [CHANNELS];
    logic [7:0]  cnt_d   [CHANNELS];
    logic [31:0] shr_q   [CHANNELS];
    logic [31:0] shr_d   [CHANNELS];
    logic [2:0]  rem_q   [CHANNELS];
    logic [2:0]  rem_d   [CHANNELS];
    logic        ovf_q   [CHANNELS];
    logic        ovf_d   [CHANNELS];

    logic [6:0]  widx;
    logic [3:0]  ch_sel;
    logic [1:0]  reg_off;
    logic        key_hit;
    logic        ch_hit;
    logic        wr_ch;
    logic        rd_req;
    logic        sub_err;
    logic        err_new;
    logic        pend_q;
    logic [3:0]  pend_ch;
    logic        pend_done;
    logic [31:0] pend_hash;
    logic        sel_busy;
    logic [31:0] sel_hash;
    logic [31:0] sel_stat;
    logic [31:0] key_word;
    logic [31:0] rd_word;
    logic        unused_bits;

    assign unused_bits = ^{io_strb, io_addr[IO_ADDR_WIDTH-1:9], io_addr[1:0]};

    // Word index: keys live below 0x100, channels at 0x100 + 0x10*c.
    assign widx    = io_addr[8:2];
    assign ch_sel  = widx[5:2];
    assign reg_off = widx[1:0];
    assign key_hit = !widx[6] && (32'(widx) < KEY_WORDS);
    assign ch_hit  = widx[6] && (32'(ch_sel) < CHANNELS);
    assign wr_ch   = io_en && io_wen && ch_hit;
    assign rd_req  = io_en && !io_wen;

    // One Toeplitz byte step: the 39-bit key window starting at bit offset 8*cnt covers all 8 taps.
    function automatic logic [31:0] hash_byte(input logic [31:0]         h,
                                              input logic [7:0]          b,
                                              input logic [KEY_BITS-1:0] k,
                                              input logic [7:0]          cnt);
        logic [KEY_BITS-1:0] sh;
        logic [38:0]         win;
        logic [31:0]         r;
        sh  = k << {cnt, 3'b000};
        win = sh[KEY_BITS-1 -: 39];
        r   = h;
        for (int j = 0; j < 8; j++) begin
            if (b[7-j]) r = r ^ win[38-j -: 32];
        end
        return r;
    endfunction

    always_comb begin
        sub_err = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            state_d[c] = state_q[c];
            hash_d[c]  = hash_q[c];
            cnt_d[c]   = cnt_q[c];
            shr_d[c]   = shr_q[c];
            rem_d[c]   = rem_q[c];
            ovf_d[c]   = ovf_q[c];
            if (state_q[c] == BUSY) begin
                if (cnt_q[c] == SAT_CNT) begin
                    ovf_d[c] = 1'b1;
                end else begin
                    hash_d[c] = hash_byte(hash_q[c], shr_q[c][7:0], key_q, cnt_q[c]);
                    cnt_d[c]  = cnt_q[c] + 8'd1;
                end
                shr_d[c] = shr_q[c] >> 8;
                rem_d[c] = rem_q[c] - 3'd1;
                if (rem_q[c] == 3'd1) state_d[c] = IDLE;
            end
            // A clear overrides any in-flight byte; a submit only lands on an idle channel.
            if (wr_ch && (4'(c) == ch_sel)) begin
                if (reg_off == 2'd0) begin
                    state_d[c] = IDLE;
                    hash_d[c]  = 32'd0;
                    cnt_d[c]   = 8'd0;
                    rem_d[c]   = 3'd0;
                    ovf_d[c]   = 1'b0;
                end else if (state_q[c] == BUSY) begin
                    sub_err = 1'b1;
                end else begin
                    shr_d[c]   = io_wr_data;
                    rem_d[c]   = (reg_off == 2'd1) ? 3'd1 : (reg_off == 2'd2) ? 3'd2 : 3'd4;
                    state_d[c] = BUSY;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (rst) begin
                state_q[c] <= IDLE;
                hash_q[c]  <= 32'd0;
                cnt_q[c]   <= 8'd0;
                shr_q[c]   <= 32'd0;
                rem_q[c]   <= 3'd0;
                ovf_q[c]   <= 1'b0;
            end else begin
                state_q[c] <= state_d[c];
                hash_q[c]  <= hash_d[c];
                cnt_q[c]   <= cnt_d[c];
                shr_q[c]   <= shr_d[c];
                rem_q[c]   <= rem_d[c];
                ovf_q[c]   <= ovf_d[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q <= KEY_INIT;
        end else if (io_en && io_wen && key_hit) begin
            for (int k = 0; k < KEY_WORDS; k++) begin
                if (7'(k) == widx) key_q[KEY_BITS-1-32*k -: 32] <= io_wr_data;
            end
        end
    end

    // Pending completion uses next-state values so a clear releases the read with hash 0.
    always_comb begin
        sel_busy  = 1'b0;
        sel_hash  = 32'd0;
        sel_stat  = 32'd0;
        pend_done = 1'b0;
        pend_hash = 32'd0;
        key_word  = 32'd0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (4'(c) == ch_sel) begin
                sel_busy = (state_q[c] == BUSY);
                sel_hash = hash_q[c];
                sel_stat = {ovf_q[c], state_q[c] == BUSY, 22'd0, cnt_q[c]};
            end
            if (4'(c) == pend_ch) begin
                pend_done = (state_d[c] == IDLE);
                pend_hash = hash_d[c];
            end
        end
        for (int k = 0; k < KEY_WORDS; k++) begin
            if (7'(k) == widx) key_word = key_q[KEY_BITS-1-32*k -: 32];
        end
    end

    always_comb begin
        rd_word = 32'd0;
        if (key_hit)                         rd_word = key_word;
        else if (ch_hit && reg_off == 2'd0)  rd_word = sel_hash;
        else if (ch_hit && reg_off == 2'd1)  rd_word = sel_stat;
    end

    assign err_new = sub_err || (rd_req && pend_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            io_rd_valid <= 1'b0;
            io_rd_data  <= '0;
            pend_q      <= 1'b0;
            pend_ch     <= 4'd0;
            error       <= 1'b0;
        end else begin
            io_rd_valid <= 1'b0;
            if (pend_q) begin
                if (pend_done) begin
                    io_rd_valid <= 1'b1;
                    io_rd_data  <= pend_hash;
                    pend_q      <= 1'b0;
                end
            end else if (rd_req) begin
                if (ch_hit && reg_off == 2'd0 && sel_busy) begin
                    pend_q  <= 1'b1;
                    pend_ch <= ch_sel;
                end else begin
                    io_rd_valid <= 1'b1;
                    io_rd_data  <= rd_word;
                end
            end
            error <= err_new || (error && !error_ack);
        end
    end

endmodule

// File: doc/accel_hash_multi.md
ACCEL_HASH_MULTI -- requirements
Module: accel_hash_multi

Interface
REQ-001 The block SHALL have parameter IO_DATA_WIDTH, default 32, the IO bus data width; only 32 is supported.
REQ-002 The block SHALL have parameter IO_STRB_WIDTH, default IO_DATA_WIDTH/8, the write byte-strobe width.
REQ-003 The block SHALL have parameter IO_ADDR_WIDTH, default 22, the IO address width.
REQ-004 The block SHALL have parameter CHANNELS, default 4, the number of independent hash contexts; the legal range is 1..16.
REQ-005 The block SHALL have parameter KEY_BITS, default 320, the Toeplitz key length; it SHALL be a multiple of 32.
REQ-006 The block SHALL have parameter KEY_INIT, default 320'h6d5a56da255b0ec24167253d43a38fb0d0ca2bcbae7b30b477cb2da38030f20c6a42b73bbeac01fa, the key value loaded at reset.
REQ-007 The block SHALL have the following ports:
- clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
- rst  in  1  synchronous active-high reset.
- io_en  in  1  access strobe.
- io_wen  in  1  1 = write, 0 = read.
- io_strb  in  IO_STRB_WIDTH  byte strobes; ignored, every write is full-word.
- io_addr  in  IO_ADDR_WIDTH  byte address; only bits [8:2] are decoded.
- io_wr_data  in  32  write data.
- io_rd_data  out  32  read data.
- io_rd_valid  out  1  one-cycle read response.
- error  out  1  sticky error flag.
- error_ack  in  1  clears error.

Function
REQ-008 Key registers SHALL occupy 0x000+4k, k = 0..KEY_BITS/32-1; word 0 holds key[KEY_BITS-1:KEY_BITS-32]; these words are read/write.
REQ-009 Channel c SHALL use base B = 0x100+0x10*c.
- Write to B+0 clears the channel.
- Writes to B+4, B+8 and B+C submit 1, 2 and 4 bytes respectively.
- Read from B+0 returns the hash.
- Read from B+4 returns status {overflow[31], busy[30], 22'b0, byte_cnt[7:0]}.
REQ-010 Byte order SHALL be io_wr_data[7:0] first, then [15:8], and so on.
REQ-011 Each channel SHALL hold a 32-bit hash, a byte_cnt, a data shift register, a remaining-byte counter (0..4) and an overflow flag.
REQ-012 Each channel SHALL process one byte per clock.
- With offset o = 8*byte_cnt and byte bits b7..b0 taken MSB first, the hash SHALL be XORed with key[KEY_BITS-1-(o+j) -: 32] for every set bit b(7-j).
- byte_cnt SHALL then increment and the remaining counter SHALL decrement.
REQ-013 Channel FSM states SHALL be IDLE and BUSY.
- A submit in IDLE SHALL load the data and count and enter BUSY on the next cycle.
- BUSY SHALL return to IDLE in the cycle the last byte is consumed.
- An n-byte submit at cycle T SHALL therefore give a final hash at T+n, with busy reading 0 from T+n+1.
REQ-014 If byte_cnt = KEY_BITS/8-4 when a byte is due, that byte SHALL be discarded without hashing, overflow SHALL set, and byte_cnt SHALL saturate.
REQ-015 A submit to a BUSY channel SHALL be dropped and SHALL set error; a submit to a different, idle channel in the same cycle SHALL proceed normally.
REQ-016 A clear SHALL take priority over processing and over a simultaneous submit: hash, byte_cnt, remaining counter and overflow go to 0 and the FSM goes to IDLE on the next cycle, even mid-operation.
REQ-017 Key and status reads SHALL return io_rd_valid on the cycle after the access.
REQ-018 A hash read of an IDLE channel SHALL respond on the next cycle; a hash read of a BUSY channel SHALL be held pending and answered on the cycle after that channel reaches IDLE, with the final hash.
REQ-019 Only one read SHALL be outstanding at a time.
- A read arriving while one is pending SHALL be dropped and SHALL set error.
- A clear of the pending channel SHALL release the pending read with value 0.
REQ-020 Unmapped addresses SHALL have writes ignored and reads return 0 with normal latency.
REQ-021 A key write SHALL take effect for bytes processed from the following cycle, including bytes of in-flight channels.
REQ-022 error SHALL be sticky and SHALL be cleared by error_ack; a new error in the same cycle as error_ack SHALL win.

Reset
REQ-023 On rst, all channels SHALL enter IDLE with hash, byte_cnt, remaining counter and overflow at 0.
REQ-024 On rst, the key SHALL load KEY_INIT.
REQ-025 On rst, io_rd_valid, error and the pending-read flag SHALL go to 0, io_rd_data SHALL go to 0, and any pending read SHALL be discarded without a response.

Verification
REQ-026 Scenario 1: clear ch0; write 0xBB950942 to 0x10C; write 0x5064_8EA1 to 0x10C; read 0x100 -> 0x323E8FC2.
REQ-027 Scenario 2: extend scenario 1 with a write of 0xE606EA0A to 0x10C; read ch0 hash -> 0x51CCC178; read status -> byte_cnt 12, busy 0, overflow 0.
REQ-028 Scenario 3: a 4-byte submit on ch1 at T and a read of 0x110 at T+1 -> io_rd_valid at T+5 with the final hash; a second read at T+2 -> dropped and error=1.
REQ-029 Scenario 4: 37 single-byte submits to ch2, each spaced 2 cycles -> status byte_cnt 36, overflow 1; hash equal to that after 36 bytes.
REQ-030 Scenario 5: two submits to busy ch3 -> error=1 and the second dropped; error_ack -> error=0; clear during BUSY -> hash 0 next cycle.
REQ-031 Scenario 6: write key word 0 = 0, reset mid-BUSY -> key word 0 reads 0x6D5A56DA, all status reads 0, no stray io_rd_valid.
